// File: rtl/serial_receiver.sv
// serial_receiver
// 8N1 asynchronous serial receiver (LSB first, idle high) feeding a small
// first-word-fall-through byte FIFO.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (even, >= 4)
//   FIFO_DEPTH   : received-byte buffer entries (power of two, >= 2)
//
// Ports
//   clk               : single clock, all state changes on its rising edge
//   reset             : asynchronous, active-high reset
//   serial_rxd        : asynchronous serial input line
//   rx_read           : pop request for the head byte
//   rx_data           : head byte of the FIFO (8'h00 while empty)
//   rx_data_available : FIFO non-empty
//   rx_framing_error  : one-cycle pulse when a stop bit samples low
//   rx_overrun        : sticky, a byte was dropped because the FIFO was full
module serial_receiver #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       serial_rxd,
   input  logic       rx_read,
   output logic [7:0] rx_data,
   output logic       rx_data_available,
   output logic       rx_framing_error,
   output logic       rx_overrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);

   // Counter reload values: a value N expires N+1 edges later.  The half-bit
   // load is one short because the IDLE edge that spots the falling line
   // already counts as the first cycle of the half-bit wait.
   localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 2);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   rx_state_t     state;
   logic          sync_meta;
   logic          rxs;
   logic [1:0]    settle;
   logic          armed;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          fifo_full;
   logic          push_now;
   logic          pop;
   logic          push_ok;
   logic          push_drop;

   // Two-flop synchronizer.  After reset both flops hold a fake "idle high",
   // so 'settle' marks when rxs really reflects the line; start detection is
   // only armed once a genuine high has been seen, which keeps the tail of a
   // frame interrupted by reset from being mistaken for a new start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b1;
         rxs       <= 1'b1;
         settle    <= 2'b00;
         armed     <= 1'b0;
      end else begin
         sync_meta <= serial_rxd;
         rxs       <= sync_meta;
         settle    <= {settle[0], 1'b1};
         if (settle == 2'b11 && rxs) begin
            armed <= 1'b1;
         end
      end
   end

   // Receive state machine.  Each bit is sampled when the counter reaches
   // zero, landing near the middle of the bit; a low stop bit raises a single
   // cycle framing pulse and parks in BREAK until the line returns high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         bit_cnt          <= '0;
         bit_idx          <= '0;
         shift_reg        <= '0;
         rx_framing_error <= 1'b0;
      end else begin
         rx_framing_error <= 1'b0;
         case (state)
            IDLE: begin
               if (armed && !rxs) begin
                  state   <= START;
                  bit_cnt <= HALF_LOAD;
               end
            end
            START: begin
               if (bit_cnt == '0) begin
                  if (!rxs) begin
                     state   <= DATA;
                     bit_cnt <= BIT_LOAD;
                     bit_idx <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt - CNT_ONE;
               end
            end
            DATA: begin
               if (bit_cnt == '0) begin
                  shift_reg[bit_idx] <= rxs;
                  bit_cnt            <= BIT_LOAD;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  bit_cnt <= bit_cnt - CNT_ONE;
               end
            end
            STOP: begin
               if (bit_cnt == '0) begin
                  if (rxs) begin
                     state <= IDLE;
                  end else begin
                     rx_framing_error <= 1'b1;
                     state            <= BREAK;
                  end
               end else begin
                  bit_cnt <= bit_cnt - CNT_ONE;
               end
            end
            BREAK: begin
               if (rxs) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // A good stop sample pushes on the same edge.  When full, a simultaneous
   // pop frees the head slot first, so the push still lands.
   assign push_now  = (state == STOP) && (bit_cnt == '0) && rxs;
   assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rx_data_available = (wr_ptr != rd_ptr);
   assign pop       = rx_read && rx_data_available;
   assign push_ok   = push_now && (!fifo_full || pop);
   assign push_drop = push_now && fifo_full && !pop;

   // FIFO pointers and the sticky overrun flag; a drop on the same edge as a
   // pop keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rx_overrun <= 1'b0;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (push_drop) begin
            rx_overrun <= 1'b1;
         end else if (pop) begin
            rx_overrun <= 1'b0;
         end
      end
   end

   // Storage has no reset; the output is gated so an empty FIFO reads 8'h00.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= shift_reg;
      end
   end

   assign rx_data = rx_data_available ? mem[rd_ptr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver
// Directed-plus-random bench for serial_receiver with default parameters.
// A byte-level queue model predicts FIFO contents, availability and the
// overrun flag; framing pulses are counted by a monitor.
module tb_serial_receiver;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int LATENCY = 2 + CPB / 2 + 9 * CPB;

   logic       clk = 1'b0;
   logic       reset;
   logic       serial_rxd;
   logic       rx_read;
   logic [7:0] rx_data;
   logic       rx_data_available;
   logic       rx_framing_error;
   logic       rx_overrun;

   int checks   = 0;
   int failures = 0;
   int fe_count = 0;

   logic [7:0] model_q[$];
   logic       model_ovr;

   serial_receiver #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .serial_rxd(serial_rxd),
      .rx_read(rx_read),
      .rx_data(rx_data),
      .rx_data_available(rx_data_available),
      .rx_framing_error(rx_framing_error),
      .rx_overrun(rx_overrun)
   );

   always #5 clk = ~clk;

   // Count cycles the framing flag is high, sampled away from the active edge.
   always @(negedge clk) begin
      if (rx_framing_error === 1'b1) begin
         fe_count++;
      end
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Compare the visible FIFO state against the queue model.
   task automatic check_model(input string tag);
      check_output({tag, "_avail"}, 32'(rx_data_available), 32'(model_q.size() != 0));
      check_output({tag, "_data"}, 32'(rx_data),
                   (model_q.size() != 0) ? 32'(model_q[0]) : 32'h0);
      check_output({tag, "_ovr"}, 32'(rx_overrun), 32'(model_ovr));
   endtask

   function automatic void model_receive(input logic [7:0] b);
      if (model_q.size() < DEPTH) begin
         model_q.push_back(b);
      end else begin
         model_ovr = 1'b1;
      end
   endfunction

   function automatic void model_pop();
      if (model_q.size() != 0) begin
         void'(model_q.pop_front());
         model_ovr = 1'b0;
      end
   endfunction

   // Drive one full 8N1 frame, each bit held for CPB cycles.
   task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit);
      serial_rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         serial_rxd = data[i];
         tick(CPB);
      end
      serial_rxd = stop_bit;
      tick(CPB);
   endtask

   task automatic read_byte(input string tag);
      check_model({tag, "_pre"});
      rx_read = 1'b1;
      tick();
      rx_read = 1'b0;
      model_pop();
      check_model({tag, "_post"});
   endtask

   initial begin
      int          lat;
      int          fe_before;
      logic [7:0]  b;
      logic [7:0]  seq[4];

      reset      = 1'b1;
      serial_rxd = 1'b1;
      rx_read    = 1'b0;
      model_ovr  = 1'b0;
      tick(3);
      check_output("reset_avail", 32'(rx_data_available), 32'h0);
      check_output("reset_data", 32'(rx_data), 32'h0);
      check_output("reset_fe", 32'(rx_framing_error), 32'h0);
      check_output("reset_ovr", 32'(rx_overrun), 32'h0);
      reset = 1'b0;
      tick(2 * CPB);

      // First byte with latency measurement from the start edge.
      lat = 0;
      fork
         apply_stimulus(8'hA5, 1'b1);
         begin
            while (rx_data_available !== 1'b1 && lat < 300) begin
               tick();
               lat++;
            end
         end
      join
      $display("[TB] start-to-available latency %0d cycles (nominal %0d)", lat, LATENCY);
      check_output("latency_window", 32'(lat >= LATENCY - 1 && lat <= LATENCY + 1), 32'h1);
      model_receive(8'hA5);
      check_model("a5_rx");
      read_byte("a5_read");

      // A read while empty must not move the pointers.
      rx_read = 1'b1;
      tick();
      rx_read = 1'b0;
      check_model("empty_read");

      // Four back-to-back frames, then a fifth into a full FIFO.
      seq[0] = 8'h3C; seq[1] = 8'h01; seq[2] = 8'hFF; seq[3] = 8'h80;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(seq[i], 1'b1);
         model_receive(seq[i]);
      end
      check_model("four_rx");
      apply_stimulus(8'h55, 1'b1);
      model_receive(8'h55);
      check_model("overrun_rx");
      for (int i = 0; i < 4; i++) begin
         read_byte($sformatf("drain4_%0d", i));
      end

      // Full FIFO with a pop landing on the same edge as the stop sample.
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         tick($urandom_range(0, 20));
         apply_stimulus(b, 1'b1);
         model_receive(b);
      end
      check_model("refill");
      b = 8'($urandom);
      fork
         apply_stimulus(b, 1'b1);
         begin
            tick(LATENCY - 1);
            rx_read = 1'b1;
            tick();
            rx_read = 1'b0;
         end
      join
      model_pop();
      model_receive(b);
      check_model("push_pop_full");
      for (int i = 0; i < 4; i++) begin
         read_byte($sformatf("drain_pp_%0d", i));
      end
      check_model("pp_empty");

      // Bad stop bit followed by a long break, then a good frame.
      fe_before = fe_count;
      apply_stimulus(8'h12, 1'b0);
      tick(40 * CPB);
      serial_rxd = 1'b1;
      tick(2 * CPB);
      check_output("framing_pulses", 32'(fe_count - fe_before), 32'h1);
      check_model("framing_no_push");
      apply_stimulus(8'h34, 1'b1);
      model_receive(8'h34);
      check_model("after_break_rx");
      read_byte("after_break_read");

      // Short low glitch on an idle line.
      fe_before = fe_count;
      serial_rxd = 1'b0;
      tick(3);
      serial_rxd = 1'b1;
      tick(2 * CPB);
      check_model("glitch");
      check_output("glitch_fe", 32'(fe_count - fe_before), 32'h0);

      // Leave one byte queued, then reset in the middle of a frame.
      b = 8'($urandom);
      apply_stimulus(b, 1'b1);
      model_receive(b);
      check_model("pre_reset");
      fe_before = fe_count;
      fork
         apply_stimulus(8'h77, 1'b1);
         begin
            tick(5 * CPB + CPB / 2);
            reset = 1'b1;
            #1;
            model_q.delete();
            model_ovr = 1'b0;
            check_output("midreset_avail", 32'(rx_data_available), 32'h0);
            check_output("midreset_data", 32'(rx_data), 32'h0);
            check_output("midreset_fe", 32'(rx_framing_error), 32'h0);
            check_output("midreset_ovr", 32'(rx_overrun), 32'h0);
            tick(3 * CPB);
            reset = 1'b0;
         end
      join
      tick(2 * CPB);
      check_model("post_reset_no_push");
      check_output("post_reset_fe", 32'(fe_count - fe_before), 32'h0);
      b = 8'($urandom);
      apply_stimulus(b, 1'b1);
      model_receive(b);
      check_model("post_reset_rx");
      read_byte("post_reset_read");

      // Random frames with random gaps and occasional reads.
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         tick($urandom_range(0, 30));
         apply_stimulus(b, 1'b1);
         model_receive(b);
         check_model($sformatf("rand_rx_%0d", i));
         if ($urandom_range(0, 2) == 0) begin
            read_byte($sformatf("rand_read_%0d", i));
         end
      end
      for (int i = 0; i < DEPTH && model_q.size() != 0; i++) begin
         read_byte($sformatf("final_drain_%0d", i));
      end
      check_model("final_empty");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (even, >= 4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning received-byte buffer entries (power of two).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port serial_rxd  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 SHALL have port rx_read  input  1  pop request for the head byte.
REQ-007 SHALL have port rx_data  output  8  head byte of the FIFO, valid while rx_data_available is high.
REQ-008 SHALL have port rx_data_available  output  1  FIFO non-empty.
REQ-009 SHALL have port rx_framing_error  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port rx_overrun  output  1  sticky flag, byte dropped because the FIFO was full.

Function
REQ-011 SHALL pass serial_rxd through a two-flop synchronizer (reset value 1); all decisions use the synchronized value (rxs).
REQ-012 SHALL implement states IDLE, START, DATA, STOP, BREAK with a bit-timing counter and a 3-bit bit index.
REQ-013 IDLE: rxs==0 -> START, counter loaded for CLKS_PER_BIT/2 cycles.
REQ-014 START: at counter expiry, sample rxs; 0 -> DATA (counter = CLKS_PER_BIT, index 0); 1 -> IDLE (false start, nothing reported).
REQ-015 DATA: every CLKS_PER_BIT cycles, sample rxs into shift-register bit [index], LSB first; after index 7 -> STOP.
REQ-016 STOP: CLKS_PER_BIT cycles after the last data sample, sample rxs; 1 -> push byte and go to IDLE; 0 -> pulse rx_framing_error for exactly one cycle, discard byte, go to BREAK.
REQ-017 BREAK: stay until rxs==1, then go to IDLE; no start is detected while in BREAK.
REQ-018 Push SHALL be registered on the stop-sample edge; rx_data_available and rx_data SHALL reflect the byte immediately after that edge (first-word fall-through).
REQ-019 Push when FIFO full and no simultaneous pop: byte dropped, rx_overrun set, FIFO contents unchanged.
REQ-020 Simultaneous push and pop when full: pop then push; no overrun; occupancy unchanged.
REQ-021 rx_read while rx_data_available==0 SHALL be ignored; no pointer change.
REQ-022 rx_read while rx_data_available==1 SHALL advance the head on that edge; next byte (or empty) visible after the edge.
REQ-023 rx_overrun SHALL clear on an accepted pop (REQ-022) unless the same edge sets it again; set wins.
REQ-024 FIFO read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full = MSBs differ and low bits equal.
REQ-025 Latency, line falling edge to rx_data_available high: 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+/-1 for input phase); 154 for the default.

Reset
REQ-026 Reset SHALL asynchronously force: state IDLE, synchronizer flops 1, counters 0, FIFO empty, rx_data_available 0, rx_framing_error 0, rx_overrun 0; rx_data 8'h00.
REQ-027 Reset mid-frame SHALL abandon the frame; after release, the remainder of that frame SHALL produce no push and no flag until the line is seen low-after-high again.

Verification
REQ-028 Default parameters, send 0xA5 with a correct stop bit -> rx_data_available rises 154+/-1 cycles after the start edge, rx_data==8'hA5; pulse rx_read -> available drops next cycle.
REQ-029 Send 0x3C, 0x01, 0xFF, 0x80 back-to-back with no reads -> four bytes readable in order; rx_overrun stays 0.
REQ-030 With FIFO full (4 bytes), send 0x55 -> rx_overrun=1, reads return the original four bytes only; first accepted rx_read clears rx_overrun.
REQ-031 Send 0x12 with stop bit 0, line held low 40 bit times then high, then send 0x34 -> one rx_framing_error pulse, no push for 0x12, 0x34 received correctly.
REQ-032 Low glitch of 3 cycles on the idle line -> false start, no push, no error flag; assert reset during bit 4 of 0x77 -> all outputs at reset values, no byte for that frame.
